mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: memory stage of a small in-order pipeline.
// ALU results pass straight through with one cycle of latency.
// Loads and stores issue a single registered request on the data-memory port.
// A request waits for dmem_ready, or is aborted after TIMEOUT_CYC cycles.
module mem_lsu #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [2:0]  EX_MEM_type,
  input  logic [2:0]  EX_MEM_func,
  input  logic [31:0] EX_MEM_ALUOUT,
  input  logic [31:0] EX_MEM_rs2,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] MEM_WB_result,
  output logic        MEM_WB_valid,
  output logic [1:0]  mem_err
);

  // The wait counter only has to reach TIMEOUT_CYC-1; the abort fires on the
  // cycle that would take it to TIMEOUT_CYC.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_FUNC    = 2'b11;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      result_q, result_d;
  logic             valid_q, valid_d;
  logic [1:0]       err_q, err_d;
  logic [2:0]       func_q, func_d;
  logic [1:0]       off_q, off_d;

  logic        is_load, is_store, func_ok, misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  // Decode the incoming instruction: legality, alignment, lanes and store data.
  always_comb begin
    is_load  = (EX_MEM_type == 3'b000);
    is_store = (EX_MEM_type == 3'b010);

    // Unsigned variants exist only for loads.
    case (EX_MEM_func)
      3'b000, 3'b001, 3'b010: func_ok = 1'b1;
      3'b100, 3'b101:         func_ok = is_load;
      default:                func_ok = 1'b0;
    endcase

    case (EX_MEM_func[1:0])
      2'b01:   misaligned = EX_MEM_ALUOUT[0];
      2'b10:   misaligned = |EX_MEM_ALUOUT[1:0];
      default: misaligned = 1'b0;
    endcase

    case (EX_MEM_func[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << EX_MEM_ALUOUT[1:0];
        wdata_calc = {4{EX_MEM_rs2[7:0]}};
      end
      2'b01: begin
        be_calc    = EX_MEM_ALUOUT[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{EX_MEM_rs2[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = EX_MEM_rs2;
      end
    endcase
    if (!is_store) begin
      wdata_calc = 32'h0;
    end
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (func_q)
      3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_data = {24'h0, ld_byte};
      3'b101:  load_data = {16'h0, ld_half};
      default: load_data = dmem_rdata;
    endcase
  end

  // Next-state logic: accept in IDLE, hold the request steady in REQ.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    result_d = result_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    func_d   = func_q;
    off_d    = off_q;

    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!is_load && !is_store) begin
            valid_d  = 1'b1;
            result_d = EX_MEM_ALUOUT;
            err_d    = ERR_NONE;
          end else if (!func_ok) begin
            valid_d  = 1'b1;
            result_d = 32'h0;
            err_d    = ERR_FUNC;
          end else if (misaligned) begin
            valid_d  = 1'b1;
            result_d = 32'h0;
            err_d    = ERR_ALIGN;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = {EX_MEM_ALUOUT[31:2], 2'b00};
            be_d    = be_calc;
            wdata_d = wdata_calc;
            func_d  = EX_MEM_func;
            off_d   = EX_MEM_ALUOUT[1:0];
          end
        end
      end
      REQ: begin
        // Ready is checked first so a response on the last allowed cycle wins.
        if (dmem_ready) begin
          state_d  = IDLE;
          req_d    = 1'b0;
          valid_d  = 1'b1;
          err_d    = ERR_NONE;
          result_d = we_q ? 32'h0 : load_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = IDLE;
          req_d    = 1'b0;
          valid_d  = 1'b1;
          err_d    = ERR_TIMEOUT;
          result_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything, aborting any request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      result_q <= 32'h0;
      valid_q  <= 1'b0;
      err_q    <= ERR_NONE;
      func_q   <= 3'b000;
      off_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      func_q   <= func_d;
      off_q    <= off_d;
    end
  end

  assign stall         = (state_q == REQ);
  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_be       = be_q;
  assign dmem_wdata    = wdata_q;
  assign MEM_WB_result = result_q;
  assign MEM_WB_valid  = valid_q;
  assign mem_err       = err_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed vectors for mem_lsu, checked against a transaction-level
// reference model every cycle plus hand-computed literal expectations.
module tb_mem_lsu;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [2:0]  EX_MEM_type = 3'b0;
  logic [2:0]  EX_MEM_func = 3'b0;
  logic [31:0] EX_MEM_ALUOUT = 32'h0;
  logic [31:0] EX_MEM_rs2 = 32'h0;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic [31:0] MEM_WB_result;
  logic        MEM_WB_valid;
  logic [1:0]  mem_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  mem_lsu #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
    .EX_MEM_type(EX_MEM_type), .EX_MEM_func(EX_MEM_func),
    .EX_MEM_ALUOUT(EX_MEM_ALUOUT), .EX_MEM_rs2(EX_MEM_rs2),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .MEM_WB_result(MEM_WB_result), .MEM_WB_valid(MEM_WB_valid), .mem_err(mem_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic bit legal(input bit is_st, input logic [2:0] f);
    if (is_st) return (f <= 3'd2);
    return (f <= 3'd2) || (f == 3'd4) || (f == 3'd5);
  endfunction

  function automatic int unsigned nbytes(input logic [2:0] f);
    return 32'd1 << f[1:0];
  endfunction

  function automatic logic [3:0] lanes(input logic [2:0] f, input logic [31:0] a);
    int unsigned n;
    n = nbytes(f);
    return 4'(((32'd1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f, input logic [31:0] d);
    int unsigned n;
    logic [31:0] w;
    logic [31:0] r;
    n = nbytes(f);
    if (n == 4) return d;
    w = d & ((32'd1 << (8 * n)) - 1);
    r = 32'h0;
    for (int i = 0; i < 4; i += n) r = r | (w << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] rd);
    int unsigned n;
    logic [31:0] v;
    n = nbytes(f);
    if (n == 4) return rd;
    v = rd >> (8 * (a % 4));
    if (n == 1) begin
      v = v & 32'hFF;
      if (f < 3'd4 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'hFFFF;
      if (f < 3'd4 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  bit          m_busy = 1'b0;
  int          m_wait = 0;
  bit          m_store = 1'b0;
  logic [2:0]  m_func = 3'b0;
  logic [31:0] m_addr = 32'h0;
  bit          e_req = 1'b0, e_we = 1'b0, e_valid = 1'b0;
  logic [31:0] e_addr = 32'h0, e_wdata = 32'h0, e_result = 32'h0;
  logic [3:0]  e_be = 4'h0;
  logic [1:0]  e_err = 2'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 1'b0; m_wait = 0; e_req = 1'b0; e_we = 1'b0; e_valid = 1'b0;
      e_addr = 32'h0; e_wdata = 32'h0; e_result = 32'h0; e_be = 4'h0; e_err = 2'b0;
    end else begin
      e_valid = 1'b0;
      if (!m_busy) begin
        if (ex_valid) begin
          if (EX_MEM_type != 3'b000 && EX_MEM_type != 3'b010) begin
            e_valid = 1'b1; e_result = EX_MEM_ALUOUT; e_err = 2'd0;
          end else if (!legal(EX_MEM_type == 3'b010, EX_MEM_func)) begin
            e_valid = 1'b1; e_result = 32'h0; e_err = 2'd3;
          end else if (EX_MEM_ALUOUT % nbytes(EX_MEM_func) != 0) begin
            e_valid = 1'b1; e_result = 32'h0; e_err = 2'd1;
          end else begin
            m_busy  = 1'b1;
            m_wait  = 0;
            m_store = (EX_MEM_type == 3'b010);
            m_func  = EX_MEM_func;
            m_addr  = EX_MEM_ALUOUT;
            e_req   = 1'b1;
            e_we    = m_store;
            e_addr  = EX_MEM_ALUOUT & 32'hFFFF_FFFC;
            e_be    = lanes(EX_MEM_func, EX_MEM_ALUOUT);
            e_wdata = m_store ? store_data(EX_MEM_func, EX_MEM_rs2) : 32'h0;
          end
        end
      end else if (dmem_ready) begin
        e_valid  = 1'b1; e_err = 2'd0;
        e_result = m_store ? 32'h0 : load_val(m_func, m_addr, dmem_rdata);
        m_busy   = 1'b0; e_req = 1'b0;
      end else begin
        m_wait++;
        if (m_wait == TO) begin
          e_valid = 1'b1; e_err = 2'd2; e_result = 32'h0;
          m_busy = 1'b0; e_req = 1'b0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst_n && checking) begin
      chk("cyc.stall", stall, m_busy);
      chk("cyc.dmem_req", dmem_req, e_req);
      chk("cyc.valid", MEM_WB_valid, e_valid);
      if (e_req) begin
        chk("cyc.dmem_addr", dmem_addr, e_addr);
        chk("cyc.dmem_be", dmem_be, e_be);
        chk("cyc.dmem_we", dmem_we, e_we);
        chk("cyc.dmem_wdata", dmem_wdata, e_wdata);
      end
      if (e_valid) begin
        chk("cyc.result", MEM_WB_result, e_result);
        chk("cyc.err", mem_err, e_err);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [2:0] t, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] r);
    ex_valid = 1'b1; EX_MEM_type = t; EX_MEM_func = f; EX_MEM_ALUOUT = a; EX_MEM_rs2 = r;
  endtask

  // Operations that complete on the very next edge (ALU pass-through, rejects).
  task automatic quick_op(input string name, input logic [2:0] t, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] exp_res,
                          input logic [1:0] exp_err);
    @(posedge clk); #1;
    drive(t, f, a, 32'h5555_AAAA);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk({name, ".valid"}, MEM_WB_valid, 1'b1);
    chk({name, ".result"}, MEM_WB_result, exp_res);
    chk({name, ".err"}, mem_err, exp_err);
    chk({name, ".no_req"}, dmem_req, 1'b0);
    chk({name, ".stall"}, stall, 1'b0);
  endtask

  // A load or store; ready_cyc = REQ cycle on which ready is high (0 = never).
  task automatic mem_op(input string name, input logic [2:0] t, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] rs2,
                        input logic [31:0] rdata, input int ready_cyc,
                        input logic [31:0] exp_addr, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_res,
                        input logic [1:0] exp_err, input int exp_cycles);
    int  k;
    bit  done;
    @(posedge clk); #1;
    drive(t, f, a, rs2);
    dmem_rdata = rdata;
    @(posedge clk); #1;
    chk({name, ".req"}, dmem_req, 1'b1);
    chk({name, ".stall"}, stall, 1'b1);
    chk({name, ".addr"}, dmem_addr, exp_addr);
    chk({name, ".be"}, dmem_be, exp_be);
    chk({name, ".we"}, dmem_we, (t == 3'b010));
    if (t == 3'b010) chk({name, ".wdata"}, dmem_wdata, exp_wdata);
    // Upstream keeps presenting a different instruction; it must be ignored.
    drive(3'b011, 3'b000, 32'hDEAD_0001, 32'h0);
    k = 1;
    done = 1'b0;
    while (!done && k <= 40) begin
      dmem_ready = (k == ready_cyc);
      @(posedge clk); #1;
      if (MEM_WB_valid) done = 1'b1;
      else k++;
    end
    dmem_ready = 1'b0;
    ex_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.complete: no MEM_WB_valid within 40 cycles, expected after %0d",
               name, exp_cycles);
    end else begin
      chk({name, ".cycles"}, k, exp_cycles);
      chk({name, ".result"}, MEM_WB_result, exp_res);
      chk({name, ".err"}, mem_err, exp_err);
      chk({name, ".req_drop"}, dmem_req, 1'b0);
      chk({name, ".stall_drop"}, stall, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst.stall", stall, 1'b0);
    chk("rst.req", dmem_req, 1'b0);
    chk("rst.we", dmem_we, 1'b0);
    chk("rst.addr", dmem_addr, 32'h0);
    chk("rst.be", dmem_be, 4'h0);
    chk("rst.wdata", dmem_wdata, 32'h0);
    chk("rst.result", MEM_WB_result, 32'h0);
    chk("rst.valid", MEM_WB_valid, 1'b0);
    chk("rst.err", mem_err, 2'b0);
    rst_n = 1'b1;
    checking = 1'b1;

    quick_op("alu", 3'b011, 3'b000, 32'h1234_5678, 32'h1234_5678, 2'b00);
    quick_op("alu2", 3'b111, 3'b010, 32'hCAFE_F00D, 32'hCAFE_F00D, 2'b00);

    mem_op("lb",  3'b000, 3'b000, 32'h103, 32'h0, 32'h80FF_0011, 1,
           32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80, 2'b00, 1);
    mem_op("lbu", 3'b000, 3'b100, 32'h103, 32'h0, 32'h80FF_0011, 1,
           32'h100, 4'b1000, 32'h0, 32'h0000_0080, 2'b00, 1);
    mem_op("lh",  3'b000, 3'b001, 32'h102, 32'h0, 32'h80FF_0011, 2,
           32'h100, 4'b1100, 32'h0, 32'hFFFF_80FF, 2'b00, 2);
    mem_op("lhu", 3'b000, 3'b101, 32'h102, 32'h0, 32'h80FF_0011, 1,
           32'h100, 4'b1100, 32'h0, 32'h0000_80FF, 2'b00, 1);
    mem_op("lb0", 3'b000, 3'b000, 32'h104, 32'h0, 32'h1122_3344, 1,
           32'h104, 4'b0001, 32'h0, 32'h0000_0044, 2'b00, 1);
    mem_op("lw",  3'b000, 3'b010, 32'h104, 32'h0, 32'h80FF_0011, 3,
           32'h104, 4'b1111, 32'h0, 32'h80FF_0011, 2'b00, 3);
    mem_op("sh",  3'b010, 3'b001, 32'h202, 32'hAAAA_BEEF, 32'h0, 1,
           32'h200, 4'b1100, 32'hBEEF_BEEF, 32'h0, 2'b00, 1);
    mem_op("sb",  3'b010, 3'b000, 32'h301, 32'h1234_5678, 32'h0, 2,
           32'h300, 4'b0010, 32'h7878_7878, 32'h0, 2'b00, 2);
    mem_op("sw",  3'b010, 3'b010, 32'h3FC, 32'hDEAD_BEEF, 32'h0, 1,
           32'h3FC, 4'b1111, 32'hDEAD_BEEF, 32'h0, 2'b00, 1);

    quick_op("lw_mis",   3'b000, 3'b010, 32'h101, 32'h0, 2'b01);
    quick_op("lw_mis2",  3'b000, 3'b010, 32'h102, 32'h0, 2'b01);
    quick_op("lh_mis",   3'b000, 3'b001, 32'h103, 32'h0, 2'b01);
    quick_op("sh_mis",   3'b010, 3'b001, 32'h201, 32'h0, 2'b01);
    quick_op("ld_f111",  3'b000, 3'b111, 32'h100, 32'h0, 2'b11);
    quick_op("ld_f111m", 3'b000, 3'b111, 32'h101, 32'h0, 2'b11);
    quick_op("st_f100",  3'b010, 3'b100, 32'h200, 32'h0, 2'b11);

    mem_op("lw_to",  3'b000, 3'b010, 32'h500, 32'h0, 32'h1357_9BDF, 0,
           32'h500, 4'b1111, 32'h0, 32'h0, 2'b10, TO);
    mem_op("lw_r16", 3'b000, 3'b010, 32'h500, 32'h0, 32'h1357_9BDF, TO,
           32'h500, 4'b1111, 32'h0, 32'h1357_9BDF, 2'b00, TO);
    mem_op("lw_r15", 3'b000, 3'b010, 32'h504, 32'h0, 32'h2468_ACE0, TO - 1,
           32'h504, 4'b1111, 32'h0, 32'h2468_ACE0, 2'b00, TO - 1);

    // Reset in the middle of a request.
    @(posedge clk); #1;
    drive(3'b000, 3'b010, 32'h400, 32'h0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("rstreq.req", dmem_req, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rstreq.req_now", dmem_req, 1'b0);
    chk("rstreq.stall_now", stall, 1'b0);
    chk("rstreq.addr_now", dmem_addr, 32'h0);
    chk("rstreq.be_now", dmem_be, 4'h0);
    chk("rstreq.valid_now", MEM_WB_valid, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("rstreq.no_pulse", MEM_WB_valid, 1'b0);
    end

    quick_op("alu_after", 3'b001, 3'b000, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 2'b00);
    @(posedge clk); #1;
    checking = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
